// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg: PS/2 scancode constants, decoder states and host-response helper
package ps2_key_decoder_pkg;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  function automatic logic is_host_resp(input logic [7:0] b);
    return b == PS2_ACK || b == PS2_BAT || b == PS2_ECHO || b == PS2_RESEND;
  endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises PS/2 lines, shifts in 11-bit frames and validates start/stop/parity
module ps2_rx_frame #(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_prev, fall, done, frame_ok;
  logic [3:0] cnt;
  logic [10:0] sr;
  logic [TW-1:0] idle;
  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign frame_ok = ~sr[0] & sr[10] & ^sr[9:1];
  // Metastability synchronisers plus one extra ps2_clk flop for falling-edge detection
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  // Shift LSB-first on each falling edge; drop a stalled partial frame after the idle limit
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      cnt  <= '0;
      sr   <= '0;
      idle <= '0;
      done <= 1'b0;
    end else begin
      done <= fall && cnt == 4'd10;
      if (fall) begin
        sr   <= {dat_sync[SYNC_STAGES-1], sr[10:1]};
        cnt  <= cnt == 4'd10 ? 4'd0 : cnt + 4'd1;
        idle <= '0;
      end else if (cnt != 4'd0) begin
        if (idle == TW'(TIMEOUT_CYC - 1)) begin
          cnt  <= '0;
          sr   <= '0;
          idle <= '0;
        end else idle <= idle + 1'b1;
      end
    end
  // Judge the completed frame one clock after its stop bit lands
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      byte_vld  <= done & frame_ok;
      frame_err <= done & ~frame_ok;
      rx_byte   <= sr[8:1];
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 frames into held make code, press pulse and press count
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] makecode,
  output logic       ext,
  output logic       key_down,
  output logic       make_pulse,
  output logic [7:0] press_cnt,
  output logic       frame_err
);
  logic byte_vld, is_ext, match, do_make, do_brk;
  logic [7:0] rx_byte;
  state_t st;
  ps2_rx_frame #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_vld(byte_vld), .rx_byte(rx_byte), .frame_err(frame_err)
  );
  // Classify the incoming byte against the current prefix state and the held key
  always_comb begin
    is_ext  = st == ST_EXT || st == ST_EXT_BRK;
    match   = rx_byte == makecode && ext == is_ext;
    do_make = byte_vld && !(key_down && match) &&
              ((st == ST_IDLE && rx_byte != PS2_EXT && rx_byte != PS2_BRK && !is_host_resp(rx_byte)) ||
               (st == ST_EXT && rx_byte != PS2_BRK));
    do_brk  = byte_vld && (st == ST_BRK || st == ST_EXT_BRK) && match;
  end
  // Prefix FSM and registered key outputs, advancing only on accepted bytes
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      st         <= ST_IDLE;
      makecode   <= '0;
      ext        <= 1'b0;
      key_down   <= 1'b0;
      make_pulse <= 1'b0;
      press_cnt  <= '0;
    end else begin
      make_pulse <= do_make;
      if (byte_vld)
        st <= st == ST_IDLE ? (rx_byte == PS2_EXT ? ST_EXT : rx_byte == PS2_BRK ? ST_BRK : ST_IDLE) :
              st == ST_EXT  ? (rx_byte == PS2_BRK ? ST_EXT_BRK : ST_IDLE) : ST_IDLE;
      if (do_make) begin
        makecode  <= rx_byte;
        ext       <= is_ext;
        key_down  <= 1'b1;
        press_cnt <= press_cnt + 8'd1;
      end else if (do_brk) begin
        makecode <= '0;
        ext      <= 1'b0;
        key_down <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frame stimulus checked against a byte-level key model
module tb_ps2_key_decoder;
  localparam int TO = 64, H = 6, GAP = 10;
  logic clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] makecode, press_cnt;
  logic ext, key_down, make_pulse, frame_err;
  int vectors = 0, miscompares = 0, n_make = 0, n_err = 0, exp_make = 0, exp_err = 0;
  logic [7:0] m_code = 8'h00, m_cnt = 8'h00;
  logic m_ext = 1'b0, m_down = 1'b0, p_ext = 1'b0, p_brk = 1'b0;

  ps2_key_decoder #(.SYNC_STAGES(3), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .makecode(makecode), .ext(ext), .key_down(key_down), .make_pulse(make_pulse),
    .press_cnt(press_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (make_pulse) n_make++;
    if (frame_err) n_err++;
    if (make_pulse && frame_err) begin
      miscompares++;
      $display("FAIL pulse_overlap: make_pulse=1 frame_err=1 in same clk, required not both");
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      idle(H);
      ps2_clk = 1'b0;
      idle(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic model_reset();
    m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_cnt = 8'h00; p_ext = 1'b0; p_brk = 1'b0;
  endtask

  task automatic model_make(input logic [7:0] b, input logic e);
    if (!(m_down && m_code == b && m_ext == e)) begin
      m_code = b; m_ext = e; m_down = 1'b1; m_cnt = m_cnt + 8'd1; exp_make++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (p_brk) begin
      if (m_code == b && m_ext == p_ext) begin m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; end
      p_brk = 1'b0; p_ext = 1'b0;
    end else if (p_ext) begin
      if (b == 8'hF0) p_brk = 1'b1;
      else begin model_make(b, 1'b1); p_ext = 1'b0; end
    end else if (b == 8'hE0) p_ext = 1'b1;
    else if (b == 8'hF0) p_brk = 1'b1;
    else if (!(b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE)) model_make(b, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b), 11);
    idle(GAP);
    model_byte(b);
  endtask

  task automatic send_bad(input int kind, input logic [7:0] b);
    logic [10:0] f;
    int k;
    f = frame(b);
    k = kind == 0 ? 9 : kind == 1 ? 0 : 10;
    f[k] = ~f[k];
    send_bits(f, 11);
    idle(GAP);
    exp_err++;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    idle(3);
    vectors++;
    if ({makecode, ext, key_down, make_pulse, press_cnt, frame_err} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset: got code=%h ext=%b down=%b pulse=%b cnt=%h err=%b, want all 0",
               makecode, ext, key_down, make_pulse, press_cnt, frame_err);
    end
    clrn = 1'b1;
    model_reset();
    idle(3);
  endtask

  task automatic test_make_repeat_break();
    send_byte(8'h1C);
    vectors++;
    if ({makecode, ext, key_down, press_cnt} !== {8'h1C, 1'b0, 1'b1, 8'h01} || n_make != exp_make) begin
      miscompares++;
      $display("FAIL make_1c: got code=%h ext=%b down=%b cnt=%h pulses=%0d, want 1c/0/1/01 pulses=%0d",
               makecode, ext, key_down, press_cnt, n_make, exp_make);
    end
    repeat (3) send_byte(8'h1C);
    vectors++;
    if (press_cnt !== 8'h01 || n_make != exp_make) begin
      miscompares++;
      $display("FAIL repeat_1c: got cnt=%h pulses=%0d, want cnt=01 pulses=%0d", press_cnt, n_make, exp_make);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    vectors++;
    if ({makecode, ext, key_down} !== {8'h00, 1'b0, 1'b0} || press_cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL break_1c: got code=%h ext=%b down=%b cnt=%h, want 00/0/0/01", makecode, ext, key_down, press_cnt);
    end
  endtask

  task automatic test_parity_err();
    send_byte(8'h1C);
    send_bad(0, 8'h1C);
    vectors++;
    if ({makecode, press_cnt} !== {m_code, m_cnt} || n_err != exp_err || n_make != exp_make) begin
      miscompares++;
      $display("FAIL parity_err: got code=%h cnt=%h errs=%0d pulses=%0d, want %h/%h errs=%0d pulses=%0d",
               makecode, press_cnt, n_err, n_make, m_code, m_cnt, exp_err, exp_make);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    vectors++;
    if ({makecode, key_down, press_cnt} !== {8'h1C, 1'b1, m_cnt} || n_make != exp_make) begin
      miscompares++;
      $display("FAIL after_err: got code=%h down=%b cnt=%h pulses=%0d, want 1c/1/%h pulses=%0d",
               makecode, key_down, press_cnt, n_make, m_cnt, exp_make);
    end
  endtask

  task automatic test_ext();
    send_byte(8'hE0);
    send_byte(8'h75);
    vectors++;
    if ({makecode, ext, key_down} !== {8'h75, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ext_make: got code=%h ext=%b down=%b, want 75/1/1", makecode, ext, key_down);
    end
    send_byte(8'hF0);
    send_byte(8'h75);
    vectors++;
    if ({makecode, ext, key_down} !== {8'h75, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL plain_break_ignored: got code=%h ext=%b down=%b, want 75/1/1", makecode, ext, key_down);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    vectors++;
    if ({makecode, ext, key_down} !== {8'h00, 1'b0, 1'b0} || press_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL ext_break: got code=%h ext=%b down=%b cnt=%h, want 00/0/0/%h", makecode, ext, key_down, press_cnt, m_cnt);
    end
  endtask

  task automatic test_host_cmds();
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'hEE);
    send_byte(8'hFE);
    vectors++;
    if ({makecode, key_down, press_cnt} !== {m_code, m_down, m_cnt} || n_make != exp_make) begin
      miscompares++;
      $display("FAIL host_cmds: got code=%h down=%b cnt=%h pulses=%0d, want %h/%b/%h pulses=%0d",
               makecode, key_down, press_cnt, n_make, m_code, m_down, m_cnt, exp_make);
    end
  endtask

  task automatic test_timeout();
    send_bits(frame(8'h2B), 5);
    idle(TO + 40);
    send_byte(8'h16);
    vectors++;
    if ({makecode, key_down} !== {8'h16, 1'b1} || n_err != exp_err || n_make != exp_make) begin
      miscompares++;
      $display("FAIL timeout: got code=%h down=%b errs=%0d pulses=%0d, want 16/1 errs=%0d pulses=%0d",
               makecode, key_down, n_err, n_make, exp_err, exp_make);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r;
    for (int it = 0; it < 100; it++) begin
      r = $urandom_range(0, 9);
      c = 8'($urandom_range(1, 8'h7F));
      if (r <= 2) send_byte(c);
      else if (r == 3) begin send_byte(8'hE0); send_byte(c); end
      else if (r <= 5) begin
        if (r == 4 && m_down) c = m_code;
        if (r == 4 && m_ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(c);
      end else if (r == 6) send_bad($urandom_range(0, 2), c);
      else if (r == 7) send_byte(8'hFA);
      else begin
        if (m_down) begin
          if (m_ext) send_byte(8'hE0);
          send_byte(m_code);
        end else send_byte(c);
      end
      vectors++;
      if ({makecode, ext, key_down, press_cnt} !== {m_code, m_ext, m_down, m_cnt} ||
          n_make != exp_make || n_err != exp_err) begin
        miscompares++;
        $display("FAIL random[%0d]: got code=%h ext=%b down=%b cnt=%h pulses=%0d errs=%0d, want %h/%b/%b/%h pulses=%0d errs=%0d",
                 it, makecode, ext, key_down, press_cnt, n_make, n_err, m_code, m_ext, m_down, m_cnt, exp_make, exp_err);
      end
    end
  endtask

  task automatic test_wrap();
    int start;
    test_reset();
    start = n_make;
    for (int i = 0; i < 256; i++) send_byte(i[0] ? 8'h1B : 8'h1C);
    vectors++;
    if (press_cnt !== 8'h00 || n_make - start != 256) begin
      miscompares++;
      $display("FAIL wrap: got cnt=%h presses=%0d, want cnt=00 presses=256", press_cnt, n_make - start);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(frame(8'h2B), 5);
    clrn = 1'b0;
    idle(2);
    vectors++;
    if ({makecode, ext, key_down, make_pulse, press_cnt, frame_err} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got code=%h ext=%b down=%b pulse=%b cnt=%h err=%b, want all 0",
               makecode, ext, key_down, make_pulse, press_cnt, frame_err);
    end
    clrn = 1'b1;
    model_reset();
    idle(3);
    send_byte(8'h1C);
    vectors++;
    if ({makecode, ext, key_down, press_cnt} !== {8'h1C, 1'b0, 1'b1, 8'h01} || n_err != exp_err) begin
      miscompares++;
      $display("FAIL after_reset_mid: got code=%h ext=%b down=%b cnt=%h errs=%0d, want 1c/0/1/01 errs=%0d",
               makecode, ext, key_down, press_cnt, n_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_make_repeat_break();
    test_parity_err();
    test_ext();
    test_host_cmds();
    test_timeout();
    test_random();
    test_wrap();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
